wb_arb2: RTL and testbench

- Two-master to one-slave Wishbone arbiter that shares the external SRAM port (wb_sram16) between the LM32 path from the interconnect and a second master, e.g. a farbborg frame-fetch DMA.
- Sits between the interconnect's sram0 slave port plus the second master on one side, and wb_sram16 on the other.
- Round-robin, grant held for the whole CYC, zero-bubble handover.

---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/wb_arb_rr2.sv | 79 +++++++
 rtl/wb_arb2.sv | 77 +++++++
 tb/tb_wb_arb2.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM encoding, master
// request bundle and a constant clog2 helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
  } wb_req_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_rr2.sv
// Round-robin grant FSM for two Wishbone masters, grant held for the whole CYC.
// Optional ACK watchdog enabled by `define WB_ARB_TIMEOUT_EN.
module wb_arb_rr2
  import wb_arb_pkg::*;
#(
  parameter int timeout_cycles = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cyc,
  input  logic [1:0] stb,
  input  logic       ack,
  output logic [1:0] gnt,
  output logic [1:0] err,
  output logic       abort
);

  arb_state_e state, state_nxt;
  logic       last_gnt;
  logic [1:0] gnt_r;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (cyc[0] && cyc[1]) state_nxt = last_gnt ? ST_GNT0 : ST_GNT1;
        else if (cyc[0])      state_nxt = ST_GNT0;
        else if (cyc[1])      state_nxt = ST_GNT1;
      // release or watchdog abort hands straight to a waiting peer
      ST_GNT0:
        if (!cyc[0] || abort) state_nxt = cyc[1] ? ST_GNT1 : ST_IDLE;
      ST_GNT1:
        if (!cyc[1] || abort) state_nxt = cyc[0] ? ST_GNT0 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_GNT0)      last_gnt <= 1'b0;
      else if (state_nxt == ST_GNT1) last_gnt <= 1'b1;
    end
  end

  assign gnt_r = {state == ST_GNT1, state == ST_GNT0};
  // reset also kills the grant combinationally so no ACK leaks in the reset cycle
  assign gnt   = reset ? 2'b00 : gnt_r;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int                CNT_W  = clog2(timeout_cycles + 1);
  localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(timeout_cycles);

  logic [CNT_W-1:0] cnt;
  logic             busy;

  assign busy  = |(gnt_r & cyc & stb);
  assign abort = (state != ST_IDLE) && (cnt == TO_VAL);
  assign err   = abort ? gnt : 2'b00;

  always_ff @(posedge clk) begin
    if (reset || ack || (state_nxt != state && state_nxt != ST_IDLE))
      cnt <= '0;
    else if (busy && cnt != TO_VAL)
      cnt <= cnt + 1'b1;
  end
`else
  localparam int unused_timeout = timeout_cycles;
  logic unused_in;

  assign unused_in = ^{stb, ack};
  assign abort     = 1'b0;
  assign err       = 2'b00;
`endif

endmodule

// File: rtl/wb_arb2.sv
// Two-master to one-slave Wishbone arbiter in front of wb_sram16.
// Datapath muxing only; arbitration lives in wb_arb_rr2 (WB_ARB_TIMEOUT_EN adds the ACK watchdog).
module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int adr_width      = 32,
  parameter int timeout_cycles = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic [adr_width-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [31:0]          s_dat_i,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic                 s_ack_i,
  output logic [1:0]           gnt_o
);

  logic [1:0] gnt, err;
  logic       abort, owned, live;
  wb_req_t    req0, req1, req_g;

  wb_arb_rr2 #(.timeout_cycles(timeout_cycles)) u_rr (
    .clk   (clk),
    .reset (reset),
    .cyc   ({m1_cyc_i, m0_cyc_i}),
    .stb   ({m1_stb_i, m0_stb_i}),
    .ack   (s_ack_i),
    .gnt   (gnt),
    .err   (err),
    .abort (abort)
  );

  assign req0  = '{dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i, cyc: m0_cyc_i, stb: m0_stb_i};
  assign req1  = '{dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i, cyc: m1_cyc_i, stb: m1_stb_i};
  assign req_g = gnt[1] ? req1 : req0;
  assign owned = |gnt;
  assign live  = owned & ~abort;

  // m0 drives adr/dat/sel while idle; control lines are what matter there
  assign s_adr_o = gnt[1] ? m1_adr_i : m0_adr_i;
  assign s_dat_o = req_g.dat;
  assign s_sel_o = req_g.sel;
  assign s_we_o  = req_g.we  & owned;
  assign s_cyc_o = req_g.cyc & live;
  assign s_stb_o = req_g.stb & live;

  assign m0_ack_o = gnt[0] & s_ack_i & ~abort;
  assign m1_ack_o = gnt[1] & s_ack_i & ~abort;
  assign m0_err_o = err[0];
  assign m1_err_o = err[1];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = gnt;

endmodule

// File: tb/tb_wb_arb2.sv
// Scoreboard bench for wb_arb2: bus-functional masters/slave, expected beats
// queued by the stimulus and popped by a monitor on every master ACK.
module tb_wb_arb2;

  localparam logic [31:0] MUTE_ADR = 32'hDEAD0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_adr_i = '0, m1_adr_i = '0, m0_dat_i = '0, m1_dat_i = '0;
  logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
  logic        m0_we_i = 0, m1_we_i = 0, m0_cyc_i = 0, m1_cyc_i = 0, m0_stb_i = 0, m1_stb_i = 0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [31:0] s_dat_i = '0;
  logic [3:0]  s_sel_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o;
  logic        s_ack_i = 1'b0;
  logic [1:0]  gnt_o;

  always #5 clk = ~clk;

  wb_arb2 #(.adr_width(32), .timeout_cycles(8)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  typedef struct {
    logic [31:0] adr, dat;
    logic        we;
    logic [3:0]  sel;
    int          beats;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } exp_t;

  cmd_t q0[$], q1[$];
  exp_t sb[$];
  int   n_vec = 0, n_bad = 0, cyc_n = 0, ack_dly = 1;
  int   ack0_cnt = 0, ack1_cnt = 0, bubbles = 0;
  bit   spur = 0, rr_win = 0, seen_gnt = 0;
  bit   act[2];

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return (a == 32'h400) ? 32'hCAFEBABE : {a[15:0], 16'hA5A5};
  endfunction

  task automatic chk(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [31:0] adr, input logic we,
                          input logic [3:0] sel, input logic [31:0] dat);
    sb.push_back('{gnt: g, ack: g, adr: adr, we: we, sel: sel, dat: dat});
  endtask

  task automatic cmd(input int m, input logic [31:0] adr, input logic [31:0] dat,
                     input logic we, input logic [3:0] sel, input int beats);
    cmd_t c;
    c = '{adr: adr, dat: dat, we: we, sel: sel, beats: beats};
    if (m == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  task automatic wait_gnt(input string name, input logic [1:0] g, input int budget);
    int n = 0;
    while (gnt_o !== g && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, gnt_o, g);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || act[0] || act[1] || q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
    tick(2);
  endtask

  always @(posedge clk) cyc_n++;

  // Bus-functional masters and slave: decide at negedge, drive just after posedge.
  initial begin : bfm
    cmd_t        cur[2];
    int          beat[2];
    logic [31:0] d_adr[2], d_dat[2];
    logic [3:0]  d_sel[2];
    logic        d_we[2], d_cyc[2];
    logic [1:0]  mack, merr;
    logic [31:0] ndat;
    bit          nack;
    int          wcnt;
    wcnt = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; beat[i] = 0; d_adr[i] = '0; d_dat[i] = '0; d_sel[i] = '0; d_we[i] = 0; d_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      mack = {m1_ack_o, m0_ack_o};
      merr = {m1_err_o, m0_err_o};
      nack = 0;
      ndat = '0;
      if (reset) begin
        wcnt = 0;
        for (int i = 0; i < 2; i++) begin
          act[i] = 0; d_cyc[i] = 0;
        end
      end else begin
        if (s_cyc_o && s_stb_o && !s_ack_i) begin
          wcnt++;
          if (wcnt >= ack_dly && s_adr_o != MUTE_ADR) begin
            nack = 1;
            ndat = rd_data(s_adr_o);
          end
        end else wcnt = 0;
        if (spur) begin
          nack = 1;
          spur = 0;
        end
        for (int i = 0; i < 2; i++) begin
          if (act[i] && (mack[i] || merr[i])) begin
            beat[i]++;
            if (merr[i] || beat[i] == cur[i].beats) begin
              act[i] = 0; d_cyc[i] = 0;
            end else begin
              d_adr[i] = cur[i].adr + 32'(4 * beat[i]);
              d_dat[i] = cur[i].dat + 32'(beat[i]);
            end
          end else if (!act[i] && ((i == 0) ? q0.size() : q1.size()) != 0) begin
            cur[i]   = (i == 0) ? q0.pop_front() : q1.pop_front();
            act[i]   = 1; beat[i] = 0;
            d_adr[i] = cur[i].adr; d_dat[i] = cur[i].dat;
            d_we[i]  = cur[i].we;  d_sel[i] = cur[i].sel; d_cyc[i] = 1;
          end
        end
      end
      @(posedge clk);
      #1;
      s_ack_i  = nack;      s_dat_i  = ndat;
      m0_adr_i = d_adr[0];  m0_dat_i = d_dat[0]; m0_sel_i = d_sel[0]; m0_we_i = d_we[0];
      m0_cyc_i = d_cyc[0];  m0_stb_i = d_cyc[0];
      m1_adr_i = d_adr[1];  m1_dat_i = d_dat[1]; m1_sel_i = d_sel[1]; m1_we_i = d_we[1];
      m1_cyc_i = d_cyc[1];  m1_stb_i = d_cyc[1];
    end
  end

  // Monitor: every master ACK must match the next queued beat.
  always @(negedge clk) begin
    exp_t a, e;
    if (m0_ack_o) ack0_cnt++;
    if (m1_ack_o) ack1_cnt++;
    if (rr_win) begin
      if (gnt_o != 2'b00) seen_gnt = 1;
      else if (seen_gnt && (m0_cyc_i || m1_cyc_i)) bubbles++;
    end
    if (m0_ack_o || m1_ack_o) begin
      a = '{gnt: gnt_o, ack: {m1_ack_o, m0_ack_o}, adr: s_adr_o, we: s_we_o, sel: s_sel_o,
            dat: s_we_o ? s_dat_o : (gnt_o[1] ? m1_dat_o : m0_dat_o)};
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_ack: got gnt=%b ack=%b adr=%h, expected no ack", a.gnt, a.ack, a.adr);
      end else begin
        e = sb.pop_front();
        chk("beat", a, e);
      end
    end
  end

  initial begin : stim
    int a0, a1, t0, n;
    reset = 1;
    tick(3);
    chk("reset_outputs", {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, gnt_o}, '0);
    @(posedge clk); #1 reset = 0;
    tick(2);
    chk("idle_gnt", gnt_o, 2'b00);

    // single read, slave acks after 2 cycles
    ack_dly = 2;
    a0 = ack0_cnt; a1 = ack1_cnt;
    push_exp(2'b01, 32'h400, 1'b0, 4'hF, 32'hCAFEBABE);
    cmd(0, 32'h400, 32'h0, 1'b0, 4'hF, 1);
    n = 0;
    while (!m0_cyc_i && n < 5) begin tick(); n++; end
    chk("arb_latency_c0", {m0_cyc_i, s_cyc_o}, 2'b10);
    tick();
    chk("arb_latency_c1", s_cyc_o, 1'b1);
    drain("drain_read", 50);
    chk("m0_ack_once", ack0_cnt - a0, 1);
    chk("m1_no_ack", ack1_cnt - a1, 0);

    // spurious slave ACK while idle
    a0 = ack0_cnt; a1 = ack1_cnt;
    @(posedge clk); spur = 1;
    tick(2);
    chk("spurious_ack", {gnt_o, m1_ack_o, m0_ack_o}, 4'b0000);
    tick(2);
    chk("spurious_cnt", (ack0_cnt - a0) + (ack1_cnt - a1), 0);

    // reset restores last_gnt so m0 wins the first tie
    @(posedge clk); #1 reset = 1;
    tick(2);
    @(posedge clk); #1 reset = 0;
    tick(2);

    // round robin with simultaneous requests
    ack_dly = 1;
    #2 rr_win = 1; seen_gnt = 0; bubbles = 0;
    push_exp(2'b01, 32'h10, 1'b1, 4'hF, 32'hA0000001);
    push_exp(2'b10, 32'h20, 1'b1, 4'hC, 32'hB0000001);
    push_exp(2'b01, 32'h14, 1'b1, 4'h3, 32'hA0000002);
    push_exp(2'b10, 32'h24, 1'b0, 4'hF, 32'h0024A5A5);
    push_exp(2'b01, 32'h18, 1'b0, 4'hF, 32'h0018A5A5);
    push_exp(2'b10, 32'h28, 1'b1, 4'h1, 32'hB0000003);
    cmd(0, 32'h10, 32'hA0000001, 1'b1, 4'hF, 1);
    cmd(0, 32'h14, 32'hA0000002, 1'b1, 4'h3, 1);
    cmd(0, 32'h18, 32'h0,        1'b0, 4'hF, 1);
    cmd(1, 32'h20, 32'hB0000001, 1'b1, 4'hC, 1);
    cmd(1, 32'h24, 32'h0,        1'b0, 4'hF, 1);
    cmd(1, 32'h28, 32'hB0000003, 1'b1, 4'h1, 1);
    drain("drain_rr", 200);
    chk("rr_bubbles", bubbles, 0);
    #2 rr_win = 0;

    // m1 burst keeps the grant while m0 waits
    for (int i = 0; i < 4; i++)
      push_exp(2'b10, 32'h800 + 32'(4 * i), 1'b1, 4'h6, 32'h11110000 + 32'(i));
    push_exp(2'b01, 32'h30, 1'b1, 4'hF, 32'hA0000004);
    cmd(1, 32'h800, 32'h11110000, 1'b1, 4'h6, 4);
    tick(2);
    cmd(0, 32'h30, 32'hA0000004, 1'b1, 4'hF, 1);
    drain("drain_burst", 200);

    // reset in the middle of a GNT1 transfer
    ack_dly = 4;
    a1 = ack1_cnt;
    cmd(1, 32'h900, 32'h22220000, 1'b1, 4'hF, 1);
    wait_gnt("gnt1_before_reset", 2'b10, 20);
    @(posedge clk); #1 reset = 1;
    tick();
    tick();
    chk("reset_mid", {s_cyc_o, s_stb_o, gnt_o, m1_ack_o}, 5'b0);
    @(posedge clk); #1 reset = 0;
    tick(2);
    chk("reset_mid_no_ack", ack1_cnt - a1, 0);
    ack_dly = 1;
    push_exp(2'b01, 32'h40, 1'b1, 4'hF, 32'hA0000005);
    push_exp(2'b10, 32'h44, 1'b1, 4'hF, 32'hB0000005);
    cmd(0, 32'h40, 32'hA0000005, 1'b1, 4'hF, 1);
    cmd(1, 32'h44, 32'hB0000005, 1'b1, 4'hF, 1);
    drain("drain_post_reset", 100);

`ifdef WB_ARB_TIMEOUT_EN
    // slave never answers m0; watchdog aborts and hands over to m1
    cmd(0, MUTE_ADR, 32'h0, 1'b1, 4'hF, 1);
    n = 0;
    while (!(s_stb_o && gnt_o == 2'b01) && n < 10) begin tick(); n++; end
    t0 = cyc_n;
    tick(2);
    push_exp(2'b10, 32'h50, 1'b1, 4'hF, 32'hB0000006);
    cmd(1, 32'h50, 32'hB0000006, 1'b1, 4'hF, 1);
    n = 0;
    while (!m0_err_o && n < 30) begin tick(); n++; end
    chk("timeout_delay", cyc_n - t0, 8);
    chk("timeout_abort", {m0_err_o, m1_err_o, s_cyc_o, s_stb_o}, 4'b1000);
    tick();
    chk("timeout_handover", {gnt_o, m0_err_o}, 3'b100);
    drain("drain_timeout", 100);
`else
    t0 = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
